// File: rtl/axi_lite_master_if.sv
// ---------------------------------------------------------------------------
// axi_lite_master_if
//
// This interface bundles the command/response channel and the AXI-lite
// master bus of axi_lite_master.
//
// Port summary:
//   cmd_*        : command request from the local client (valid/ready)
//   resp_*       : response returned to the local client (valid/ready)
//   M_AXI_AW*    : AXI-lite write-address channel
//   M_AXI_W*     : AXI-lite write-data channel
//   M_AXI_B*     : AXI-lite write-response channel
//   M_AXI_AR*    : AXI-lite read-address channel
//   M_AXI_R*     : AXI-lite read-data channel
//
// Modports:
//   master : the view used by axi_lite_master itself
//   slave  : the view used by the client and the AXI slave around it
// ---------------------------------------------------------------------------
interface axi_lite_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic        resp_timeout;

    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;

    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;

    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output resp_valid, resp_rdata, resp_status, resp_timeout,
        input  resp_ready,
        output M_AXI_AWADDR, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  resp_valid, resp_rdata, resp_status, resp_timeout,
        output resp_ready,
        input  M_AXI_AWADDR, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//
// This module is a single-outstanding AXI-lite master. A command accepted on
// the cmd channel becomes one AXI-lite write (AW+W, then B) or one read
// (AR, then R). The captured result is then presented on the resp channel
// until the client takes it. If TIMEOUT is non-zero, a transaction that
// stalls longer than TIMEOUT cycles is aborted and reported as a SLVERR
// with resp_timeout set.
//
// Parameters:
//   TIMEOUT   : maximum number of busy cycles per transaction (0 = never)
//   ADDR_MASK : mask ANDed onto cmd_addr before it is driven on AW/ARADDR
//
// Ports:
//   fclk     : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : command/response channel plus AXI-lite master bus
//   busy_cnt : number of completed transactions (wraps)
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
    input  logic              fclk,
    input  logic              rst_n,
    axi_lite_master_if.master bus,
    output logic [31:0]       busy_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RESP
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : (TIMEOUT[31:0] - 32'd1);

    state_t      state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;
    logic        timeout_q, timeout_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] busy_q, busy_d;

    logic        awvalid, wvalid;
    logic        aw_hs, w_hs;
    logic        in_txn;
    logic        progress;

    // The bus controls are decoded directly from the registered state and
    // the sticky done flags. They therefore drop the moment reset asserts,
    // and they never depend combinationally on a slave input.
    assign awvalid = (state_q == WR_AW_W) && !aw_done_q;
    assign wvalid  = (state_q == WR_AW_W) && !w_done_q;
    assign aw_hs   = awvalid && bus.M_AXI_AWREADY;
    assign w_hs    = wvalid && bus.M_AXI_WREADY;
    assign in_txn  = state_q inside {WR_AW_W, WR_B, RD_AR, RD_R};

    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_status   = status_q;
    assign bus.resp_timeout  = timeout_q;

    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWVALID = awvalid;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid;
    assign bus.M_AXI_BREADY  = (state_q == WR_B);
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARVALID = (state_q == RD_AR);
    assign bus.M_AXI_RREADY  = (state_q == RD_R);

    assign busy_cnt = busy_q;

    // State and datapath registers. A reset abandons any transaction in
    // flight, and it does so without producing a response.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            status_q  <= '0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            busy_q    <= busy_d;
        end
    end

    // This block holds the next-state logic. The "progress" signal marks a
    // cycle in which a bus handshake happens, or in which the write phase is
    // already finished. A timeout that coincides with such a cycle is
    // suppressed. The counter is compared with >= so that a handshake which
    // wins at the last cycle still leaves a working abort afterwards.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        tcnt_d    = tcnt_q;
        busy_d    = busy_q;
        progress  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d    = bus.cmd_addr & ADDR_MASK;
                    wdata_d   = bus.cmd_wdata;
                    wstrb_d   = bus.cmd_wstrb;
                    tcnt_d    = '0;
                    timeout_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.cmd_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                progress = aw_hs || w_hs || (aw_done_q && w_done_q);
                if ((aw_done_q && w_done_q) || (aw_hs && w_hs)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                progress = bus.M_AXI_BVALID;
                if (bus.M_AXI_BVALID) begin
                    status_d = bus.M_AXI_BRESP;
                    rdata_d  = '0;
                    state_d  = RESP;
                end
            end
            RD_AR: begin
                progress = bus.M_AXI_ARREADY;
                if (bus.M_AXI_ARREADY) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                progress = bus.M_AXI_RVALID;
                if (bus.M_AXI_RVALID) begin
                    rdata_d  = bus.M_AXI_RDATA;
                    status_d = bus.M_AXI_RRESP;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    busy_d  = busy_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((TIMEOUT != 0) && in_txn) begin
            if (!progress && (tcnt_q >= TIMEOUT_LAST)) begin
                state_d   = RESP;
                timeout_d = 1'b1;
                status_d  = 2'b10;
                rdata_d   = '0;
            end else if (tcnt_q != '1) begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
    end

endmodule
